// File: rtl/obstacle_amplitude_gen_pkg.sv
// Shared game definitions for the obstacle amplitude source: screen geometry,
// spawn position, draw FSM encoding and the LFSR feedback polynomial.
package obstacle_amplitude_gen_pkg;

    // Right edge of the visible screen; obstacles spawn exactly here, off-screen.
    localparam logic [9:0]  GAME_MAX_X        = 10'd640;
    localparam logic [9:0]  GAME_X_START_POS  = GAME_MAX_X;
    // Vertical centre line the obstacle oscillates around.
    localparam logic [9:0]  GAME_Y_BASELINE   = 10'd240;
    // Fallback seed used whenever a caller asks for the illegal all-zero state.
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } amp_state_t;

    // Fibonacci step for x^16+x^14+x^13+x^11+1 (taps on bits 15,13,12,10).
    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/obstacle_amplitude_gen_lfsr16.sv
// Free-running 16-bit maximal-length LFSR. Steps every clock; a zero seed is
// replaced by the default seed so the register can never lock up at zero.
module lfsr16
    import obstacle_amplitude_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    // Shift register: load the seed on reset, otherwise advance one step per clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED_SAFE;
        end else begin
            q <= lfsr16_next(q);
        end
    end

endmodule

// File: rtl/obstacle_amplitude_gen.sv
// Random amplitude source for obstacle_control. A new amplitude is drawn on every
// obstacle respawn by masking LFSR bits down to the current range and rejecting
// out-of-range candidates; after MAX_TRIES rejections a halved candidate is used.
// The maximum amplitude ramps with the number of spawns and collapses on collision.
module obstacle_amplitude_gen #(
    parameter logic [9:0]  X_START_POS      = obstacle_amplitude_gen_pkg::GAME_X_START_POS,
    parameter logic [9:0]  AMP_MIN          = 10'd0,
    parameter logic [9:0]  AMP_MAX_START    = 10'd40,
    parameter logic [9:0]  AMP_STEP         = 10'd10,
    parameter logic [9:0]  AMP_MAX_CAP      = 10'd150,
    parameter int          SPAWNS_PER_LEVEL = 5,
    parameter int          MAX_TRIES        = 8,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] obstacle_x_pos,
    input  logic       collision,
    output logic [9:0] y_amplitude_out,
    output logic       amp_update,
    output logic       draw_busy,
    output logic [3:0] level
);

    import obstacle_amplitude_gen_pkg::*;

    localparam int SCW = (SPAWNS_PER_LEVEL > 1) ? $clog2(SPAWNS_PER_LEVEL) : 1;
    localparam int TW  = $clog2(MAX_TRIES + 1);
    localparam logic [SCW-1:0] LAST_CNT = SCW'(SPAWNS_PER_LEVEL - 1);
    localparam logic [TW-1:0]  LAST_TRY = TW'(MAX_TRIES - 1);

    amp_state_t      state;
    amp_state_t      state_nxt;
    logic [15:0]     lfsr_q;
    logic            unused_lfsr_hi;
    logic            at_start_q;
    logic            spawn_evt;
    logic            pending;
    logic [SCW-1:0]  spawn_cnt;
    logic [9:0]      cur_max;
    logic [10:0]     max_stepped;
    logic [9:0]      range;
    logic [9:0]      mask;
    logic [9:0]      cand;
    logic            accept;
    logic            last_try;
    logic            draw_done;
    logic [TW-1:0]   tries;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Only the low ten bits feed the candidate; the rest just keep the sequence long.
    assign unused_lfsr_hi = ^lfsr_q[15:10];

    // Remember whether the obstacle already sat at the spawn position last clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            at_start_q <= 1'b0;
        end else begin
            at_start_q <= (obstacle_x_pos == X_START_POS);
        end
    end

    assign spawn_evt   = (obstacle_x_pos == X_START_POS) && !at_start_q;
    assign max_stepped = {1'b0, cur_max} + {1'b0, AMP_STEP};

    // Difficulty ramp: count spawns, raise the ceiling per level, collision wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spawn_cnt <= '0;
            level     <= 4'd0;
            cur_max   <= AMP_MAX_START;
        end else if (collision) begin
            spawn_cnt <= '0;
            level     <= 4'd0;
            cur_max   <= AMP_MAX_START;
        end else if (spawn_evt) begin
            if (spawn_cnt == LAST_CNT) begin
                spawn_cnt <= '0;
                if (cur_max < AMP_MAX_CAP) begin
                    if (level != 4'hF) begin
                        level <= level + 4'd1;
                    end
                    cur_max <= (max_stepped > {1'b0, AMP_MAX_CAP}) ? AMP_MAX_CAP : max_stepped[9:0];
                end
            end else begin
                spawn_cnt <= spawn_cnt + 1'b1;
            end
        end
    end

    assign range = cur_max - AMP_MIN;

    // Smallest all-ones mask covering the range, so a masked candidate is accepted
    // with probability above one half on every try.
    always_comb begin
        mask = '0;
        for (int i = 0; i < 10; i++) begin
            if (mask < range) begin
                mask = {mask[8:0], 1'b1};
            end
        end
    end

    assign cand     = lfsr_q[9:0] & mask;
    assign accept   = (cand <= range);
    assign last_try = (tries == LAST_TRY);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: start on a spawn or a queued spawn, leave once a value is chosen.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (spawn_evt || pending) state_nxt = DRAW;
            DRAW:    if (accept || last_try)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        draw_busy = (state == DRAW);
        draw_done = (state == DRAW) && (accept || last_try);
    end

    // Draw datapath: try counter, queued spawn, and the held amplitude with its pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tries           <= '0;
            pending         <= 1'b0;
            y_amplitude_out <= AMP_MIN;
            amp_update      <= 1'b0;
        end else begin
            amp_update <= 1'b0;
            if (state == IDLE) begin
                tries   <= '0;
                pending <= 1'b0;
            end else begin
                if (spawn_evt) begin
                    pending <= 1'b1;
                end
                if (draw_done) begin
                    amp_update      <= 1'b1;
                    // Halving a rejected candidate always lands inside the range,
                    // because the mask is below twice the range.
                    y_amplitude_out <= AMP_MIN + (accept ? cand : (cand >> 1));
                end else begin
                    tries <= tries + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_obstacle_amplitude_gen.sv
// Bench for obstacle_amplitude_gen: a default instance and a forced-fallback
// instance (start max 64, one try) share the stimulus. A reference model
// predicts each draw outcome from the LFSR sequence and the current range.
module tb_obstacle_amplitude_gen;

    localparam int          SPL  = 5;
    localparam int          STEP = 10;
    localparam int          CAP  = 150;
    localparam int          AMIN = 0;
    localparam int          XS   = 640;
    localparam logic [15:0] SEED = 16'hACE1;

    int start_max [2] = '{40, 64};
    int max_tries [2] = '{8, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x;
    logic       collision;
    logic [9:0] y_amp [2];
    logic       upd   [2];
    logic       busy  [2];
    logic [3:0] lvl   [2];

    always #5 clk = ~clk;

    obstacle_amplitude_gen dut (
        .clk             (clk),
        .rst             (rst),
        .obstacle_x_pos  (x),
        .collision       (collision),
        .y_amplitude_out (y_amp[0]),
        .amp_update      (upd[0]),
        .draw_busy       (busy[0]),
        .level           (lvl[0])
    );

    obstacle_amplitude_gen #(
        .AMP_MAX_START (10'd64),
        .MAX_TRIES     (1)
    ) dut_fb (
        .clk             (clk),
        .rst             (rst),
        .obstacle_x_pos  (x),
        .collision       (collision),
        .y_amplitude_out (y_amp[1]),
        .amp_update      (upd[1]),
        .draw_busy       (busy[1]),
        .level           (lvl[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model state
    logic [15:0] m_lfsr;
    bit          m_at;
    int          m_cnt [2], m_lvl [2], m_max [2], m_y [2], m_val [2];
    int          m_pulse_edge [2], m_draw_max [2];
    bit          m_drawing [2], m_pend [2], m_upd [2];
    int          n_spawn;
    int          n_pulse_obs [2];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], ^(l & 16'hB400)};
    endfunction

    // Outcome of one draw: candidates come from consecutive LFSR states.
    function automatic void draw(input logic [15:0] l0, input int rng, input int ntries,
                                 output int val, output int k);
        logic [15:0] l = l0;
        int msk = 0;
        int c;
        while (msk < rng) msk = msk * 2 + 1;
        val = AMIN;
        k   = 0;
        for (int t = 0; t < ntries; t++) begin
            c = int'(l[9:0]) & msk;
            if (c <= rng) begin
                val = AMIN + c;
                k   = t;
                return;
            end
            if (t == ntries - 1) begin
                val = AMIN + (c / 2);
                k   = t;
                return;
            end
            l = lfsr_step(l);
        end
    endfunction

    task automatic model_reset();
        m_lfsr = SEED;
        m_at   = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_cnt[m]     = 0;
            m_lvl[m]     = 0;
            m_max[m]     = start_max[m];
            m_y[m]       = AMIN;
            m_drawing[m] = 1'b0;
            m_pend[m]    = 1'b0;
            m_upd[m]     = 1'b0;
        end
    endtask

    task automatic edge_model(input int m, input bit spawn);
        bit was_draw = m_drawing[m];
        int v, k;
        m_upd[m] = 1'b0;
        if (m_drawing[m] && cyc == m_pulse_edge[m]) begin
            m_upd[m]     = 1'b1;
            m_y[m]       = m_val[m];
            m_drawing[m] = 1'b0;
        end
        if (collision) begin
            m_cnt[m] = 0;
            m_lvl[m] = 0;
            m_max[m] = start_max[m];
        end else if (spawn) begin
            if (m_cnt[m] == SPL - 1) begin
                m_cnt[m] = 0;
                if (m_max[m] < CAP) begin
                    if (m_lvl[m] < 15) m_lvl[m]++;
                    m_max[m] = (m_max[m] + STEP > CAP) ? CAP : m_max[m] + STEP;
                end
            end else begin
                m_cnt[m]++;
            end
        end
        if (spawn && was_draw) begin
            m_pend[m] = 1'b1;
        end else if (!was_draw && (spawn || m_pend[m])) begin
            draw(m_lfsr, m_max[m] - AMIN, max_tries[m], v, k);
            m_val[m]        = v;
            m_pulse_edge[m] = cyc + k + 1;
            m_draw_max[m]   = m_max[m];
            m_drawing[m]    = 1'b1;
            m_pend[m]       = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("amp_update[%0d]", m), int'(upd[m]), int'(m_upd[m]));
            check($sformatf("y_amplitude[%0d]", m), int'(y_amp[m]), m_y[m]);
            check($sformatf("draw_busy[%0d]", m), int'(busy[m]), int'(m_drawing[m]));
            check($sformatf("level[%0d]", m), int'(lvl[m]), m_lvl[m]);
            if (upd[m] === 1'b1) begin
                n_pulse_obs[m]++;
                check($sformatf("amp_in_range[%0d]", m),
                      int'(int'(y_amp[m]) >= AMIN && int'(y_amp[m]) <= m_draw_max[m]), 1);
            end
        end
    endtask

    task automatic tick();
        bit spawn;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            model_reset();
        end else begin
            m_lfsr = lfsr_step(m_lfsr);
            spawn  = (int'(x) == XS) && !m_at;
            m_at   = (int'(x) == XS);
            if (spawn) n_spawn++;
            for (int m = 0; m < 2; m++) edge_model(m, spawn);
        end
        #1;
        compare_all();
    endtask

    function automatic logic [9:0] off_x();
        int v;
        do v = $urandom_range(0, 1023); while (v == XS);
        return 10'(v);
    endfunction

    // Obstacle leaves the spawn point for a few clocks, then respawns.
    task automatic spawn_once(input bit col, input int hold, input int gap_col_pct);
        int gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
            x = off_x();
            collision = ($urandom_range(0, 99) < gap_col_pct);
            tick();
        end
        x = 10'(XS);
        collision = col;
        tick();
        collision = 1'b0;
        repeat (hold) tick();
    endtask

    initial begin
        rst = 1'b0;
        x = 10'(XS);
        collision = 1'b0;
        n_spawn = 0;
        n_pulse_obs = '{0, 0};
        model_reset();
        repeat (3) tick();

        // first draw straight out of reset with the obstacle parked at the spawn point
        rst = 1'b1;
        repeat (12) tick();
        check("first_draw_pulses", n_pulse_obs[0], 1);
        check("first_draw_level", int'(lvl[0]), 0);

        // difficulty ramp
        for (int i = 2; i <= 60; i++) begin
            spawn_once(1'b0, 11, 0);
            if (i == 5)  check("ramp_level_at_5", int'(lvl[0]), 1);
            if (i == 55) check("ramp_level_at_55", int'(lvl[0]), 11);
            if (i == 60) check("ramp_level_at_60", int'(lvl[0]), 11);
        end

        // collision on the same clock as a spawn
        for (int i = 1; i <= 12; i++) begin
            spawn_once(i == 12, 11, 0);
        end
        check("collision_level", int'(lvl[0]), 0);
        check("collision_amp_le_40", int'(y_amp[0] <= 10'd40), 1);

        // randomized spawns with occasional collisions
        for (int i = 0; i < 200; i++) begin
            spawn_once($urandom_range(0, 11) == 0, 11, 5);
        end

        // spawn arriving while a draw may still be running
        for (int i = 0; i < 12; i++) begin
            x = off_x();
            collision = 1'b1;
            tick();
            collision = 1'b0;
            x = 10'(XS);
            tick();
            x = off_x();
            tick();
            x = 10'(XS);
            repeat (14) tick();
        end

        check("pulses_vs_spawns[0]", n_pulse_obs[0], n_spawn);
        check("pulses_vs_spawns[1]", n_pulse_obs[1], n_spawn);

        // reset while a draw is in flight
        x = off_x();
        tick();
        x = 10'(XS);
        tick();
        check("busy_before_reset", int'(busy[0]), 1);
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (3) tick();
        rst = 1'b1;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
